// File: rtl/down_count_timer_pkg.sv
// Shared constants for the down-count timer:
// state encoding and default counter width.
package down_count_timer_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_COUNT = 1'b1;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/down_count_stage.sv
// One bit of the down counter: synchronous load, borrow-driven toggle,
// borrow ripple to the next more significant bit.
module down_count_stage
    import down_count_timer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ld,
    input  logic ld_bit,
    input  logic dec,
    input  logic bin,
    output logic q_bit,
    output logic bout
);

    logic q_q;
    logic q_d;

    // Next bit value: load wins, otherwise toggle when a borrow arrives.
    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = ld_bit;
        end else if (dec && bin) begin
            q_d = ~q_q;
        end
    end

    // Bit register, falling-edge with async clear.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_bit = q_q;
    assign bout  = bin & ~q_q;

endmodule

// File: rtl/down_count_timer.sv
// Loadable down-counter with one-shot / auto-reload modes.
// Borrow out of the MSB doubles as the at-zero expiry detect.
module down_count_timer
    import down_count_timer_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             expire
);

    logic             state_q;
    logic             state_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             expire_q;
    logic             expire_d;

    logic             req;
    logic             expiry;
    logic             dec;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH:0]   borrow;

    // A count request reaches the chain only when nothing outranks it.
    assign req = (state_q == ST_COUNT) && en && !abort && !start;

    // A borrow out of the MSB means the request hit q==0.
    assign borrow[0] = req;
    assign expiry    = borrow[WIDTH];
    assign dec       = req && !expiry;

    // FSM, load mux and reload capture; abort > start > count.
    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        expire_d = 1'b0;
        ld       = 1'b0;
        ld_val   = load_val;
        if (abort) begin
            state_d = ST_IDLE;
            ld      = 1'b1;
            ld_val  = '0;
        end else if (start) begin
            state_d  = ST_COUNT;
            reload_d = load_val;
            ld       = 1'b1;
        end else if (expiry) begin
            expire_d = 1'b1;
            if (AUTO_RELOAD != 0) begin
                ld     = 1'b1;
                ld_val = reload_q;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Control registers, falling-edge with async clear.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            reload_q <= '0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        down_count_stage u_stage (
            .clk    (clk),
            .reset  (reset),
            .ld     (ld),
            .ld_bit (ld_val[i]),
            .dec    (dec),
            .bin    (borrow[i]),
            .q_bit  (q[i]),
            .bout   (borrow[i+1])
        );
    end

    assign busy   = (state_q == ST_COUNT);
    assign expire = expire_q;

endmodule

// File: tb/tb_down_count_timer.sv
// Self-checking bench for down_count_timer: one-shot and
// auto-reload instances driven from shared stimulus.
module tb_down_count_timer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       en;
    logic [3:0] load_val;

    logic [3:0] q0, q1;
    logic       busy0, busy1;
    logic       exp0, exp1;

    int checks;
    int failures;

    typedef struct {
        logic       s;
        logic       a;
        logic       e;
        logic [3:0] lv;
        logic [3:0] q;
        logic       b;
        logic       x;
    } vec_t;

    typedef struct {
        int         sel;
        logic [3:0] q;
        logic       b;
        logic       x;
        string      name;
    } exp_t;

    exp_t sb[$];

    down_count_timer #(.WIDTH(4), .AUTO_RELOAD(0)) u_os (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .en(en), .load_val(load_val),
        .q(q0), .busy(busy0), .expire(exp0)
    );

    down_count_timer #(.WIDTH(4), .AUTO_RELOAD(1)) u_ar (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .en(en), .load_val(load_val),
        .q(q1), .busy(busy1), .expire(exp1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check_now(input int sel, input logic [3:0] eq,
                             input logic eb, input logic ex,
                             input string name);
        logic [3:0] aq;
        logic       ab, ax;
        aq = (sel == 0) ? q0 : q1;
        ab = (sel == 0) ? busy0 : busy1;
        ax = (sel == 0) ? exp0 : exp1;
        checks++;
        if (aq !== eq || ab !== eb || ax !== ex) begin
            failures++;
            $display("FAIL %s: got q=%0d busy=%b expire=%b want q=%0d busy=%b expire=%b",
                     name, aq, ab, ax, eq, eb, ex);
        end
    endtask

    // Drive after a rising edge, DUT updates on falling edge,
    // compare on the next rising edge.
    task automatic step(input logic s, input logic a, input logic e,
                        input logic [3:0] lv, input int sel,
                        input logic [3:0] eq, input logic eb,
                        input logic ex, input string name);
        exp_t t;
        start    = s;
        abort    = a;
        en       = e;
        load_val = lv;
        t.sel  = sel;
        t.q    = eq;
        t.b    = eb;
        t.x    = ex;
        t.name = name;
        sb.push_back(t);
        @(negedge clk);
        @(posedge clk);
        t = sb.pop_front();
        check_now(t.sel, t.q, t.b, t.x, t.name);
    endtask

    vec_t os_tab[6];
    vec_t ar_tab[7];

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        en       = 1'b0;
        load_val = 4'd0;

        os_tab[0] = '{1'b1, 1'b0, 1'b1, 4'd3, 4'd3, 1'b1, 1'b0};
        os_tab[1] = '{1'b0, 1'b0, 1'b1, 4'd3, 4'd2, 1'b1, 1'b0};
        os_tab[2] = '{1'b0, 1'b0, 1'b1, 4'd3, 4'd1, 1'b1, 1'b0};
        os_tab[3] = '{1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 1'b1, 1'b0};
        os_tab[4] = '{1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 1'b0, 1'b1};
        os_tab[5] = '{1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 1'b0, 1'b0};

        ar_tab[0] = '{1'b1, 1'b0, 1'b1, 4'd2, 4'd2, 1'b1, 1'b0};
        ar_tab[1] = '{1'b0, 1'b0, 1'b1, 4'd2, 4'd1, 1'b1, 1'b0};
        ar_tab[2] = '{1'b0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b1, 1'b0};
        ar_tab[3] = '{1'b0, 1'b0, 1'b1, 4'd2, 4'd2, 1'b1, 1'b1};
        ar_tab[4] = '{1'b0, 1'b0, 1'b1, 4'd2, 4'd1, 1'b1, 1'b0};
        ar_tab[5] = '{1'b0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b1, 1'b0};
        ar_tab[6] = '{1'b0, 1'b0, 1'b1, 4'd2, 4'd2, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        check_now(0, 4'd0, 1'b0, 1'b0, "reset_os");
        check_now(1, 4'd0, 1'b0, 1'b0, "reset_ar");
        #1 reset = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 6; i++)
            step(os_tab[i].s, os_tab[i].a, os_tab[i].e, os_tab[i].lv,
                 0, os_tab[i].q, os_tab[i].b, os_tab[i].x, "oneshot3");

        for (int i = 0; i < 7; i++)
            step(ar_tab[i].s, ar_tab[i].a, ar_tab[i].e, ar_tab[i].lv,
                 1, ar_tab[i].q, ar_tab[i].b, ar_tab[i].x, "reload2");

        step(1'b0, 1'b1, 1'b0, 4'd0, 1, 4'd0, 1'b0, 1'b0, "abort_ar");

        step(1'b1, 1'b0, 1'b0, 4'd5, 0, 4'd5, 1'b1, 1'b0, "entog_start");
        for (int k = 1; k <= 11; k++) begin
            int m;
            m = (k + 1) / 2;
            if (m <= 5)
                step(1'b0, 1'b0, k[0], 4'd9, 0, 4'(5 - m), 1'b1, 1'b0,
                     "entog");
            else
                step(1'b0, 1'b0, k[0], 4'd9, 0, 4'd0, 1'b0, 1'b1,
                     "entog_exp");
        end

        step(1'b1, 1'b0, 1'b1, 4'd3, 0, 4'd3, 1'b1, 1'b0, "pri_ld");
        step(1'b0, 1'b0, 1'b1, 4'd3, 0, 4'd2, 1'b1, 1'b0, "pri_c2");
        step(1'b0, 1'b0, 1'b1, 4'd3, 0, 4'd1, 1'b1, 1'b0, "pri_c1");
        step(1'b1, 1'b1, 1'b1, 4'd9, 0, 4'd0, 1'b0, 1'b0, "start_abort");
        step(1'b0, 1'b0, 1'b1, 4'd9, 0, 4'd0, 1'b0, 1'b0, "abort_noexp");
        step(1'b1, 1'b0, 1'b1, 4'd2, 0, 4'd2, 1'b1, 1'b0, "rs_ld");
        step(1'b0, 1'b0, 1'b1, 4'd2, 0, 4'd1, 1'b1, 1'b0, "rs_c1");
        step(1'b0, 1'b0, 1'b1, 4'd2, 0, 4'd0, 1'b1, 1'b0, "rs_c0");
        step(1'b1, 1'b0, 1'b1, 4'd7, 0, 4'd7, 1'b1, 1'b0, "restart_at0");
        step(1'b0, 1'b1, 1'b0, 4'd7, 0, 4'd0, 1'b0, 1'b0, "abort_os");

        step(1'b1, 1'b0, 1'b1, 4'd0, 0, 4'd0, 1'b1, 1'b0, "n0_ld");
        step(1'b0, 1'b0, 1'b1, 4'd0, 0, 4'd0, 1'b0, 1'b1, "n0_exp");

        step(1'b1, 1'b0, 1'b1, 4'hF, 0, 4'd15, 1'b1, 1'b0, "nF_ld");
        for (int i = 1; i <= 15; i++)
            step(1'b0, 1'b0, 1'b1, 4'd1, 0, 4'(15 - i), 1'b1, 1'b0,
                 "nF_cnt");
        step(1'b0, 1'b0, 1'b1, 4'd1, 0, 4'd0, 1'b0, 1'b1, "nF_exp");
        step(1'b0, 1'b0, 1'b1, 4'd1, 0, 4'd0, 1'b0, 1'b0, "nF_nowrap");

        step(1'b1, 1'b0, 1'b1, 4'd7, 0, 4'd7, 1'b1, 1'b0, "ar_ld");
        step(1'b0, 1'b0, 1'b1, 4'd7, 0, 4'd6, 1'b1, 1'b0, "ar_c6");
        step(1'b0, 1'b0, 1'b1, 4'd7, 0, 4'd5, 1'b1, 1'b0, "ar_c5");
        step(1'b0, 1'b0, 1'b1, 4'd7, 0, 4'd4, 1'b1, 1'b0, "ar_c4");
        #2 reset = 1'b1;
        #1;
        check_now(0, 4'd0, 1'b0, 1'b0, "async_rst_os");
        check_now(1, 4'd0, 1'b0, 1'b0, "async_rst_ar");
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        step(1'b1, 1'b0, 1'b1, 4'd1, 0, 4'd1, 1'b1, 1'b0, "post_ld");
        step(1'b0, 1'b0, 1'b1, 4'd1, 0, 4'd0, 1'b1, 1'b0, "post_c0");
        step(1'b0, 1'b0, 1'b1, 4'd1, 0, 4'd0, 1'b0, 1'b1, "post_exp");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
